// File: rtl/qpu_itcm_ctrl.sv
// rtl/qpu_itcm_ctrl.sv - ITCM SRAM initiator with 1-deep response buffer and light-sleep control
//
// Purpose: accepts valid/ready commands from the QPU fetch/load path, drives the
// ITCM SRAM pins, returns one valid/ready response per command (read data is
// taken from the SRAM one cycle after the access), and parks the SRAM in
// light-sleep after LS_IDLE idle cycles.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_read/cmd_addr/cmd_wdata/cmd_wmask  command fields (word address, byte mask)
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata/rsp_err                   read data (0 for writes/errors), range error
//   ram_cs/ram_we/ram_addr/ram_wem/ram_din  SRAM access pins
//   ram_dout                            SRAM read data, valid one cycle after a read
//   ram_sd/ram_ds/ram_ls                shutdown, deep sleep (both tied 0), light sleep

module qpu_itcm_ctrl #(
  parameter int AW      = 16,
  parameter int DW      = 64,
  parameter int MW      = 8,
  parameter int DP      = 65536,
  parameter int LS_IDLE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls
);

  // One extra bit so DP == 2**AW is representable and every address compares in range.
  localparam logic [AW:0] DP_L = (AW+1)'(DP);
  localparam int          CW   = (LS_IDLE > 0) ? $clog2(LS_IDLE + 1) : 1;
  localparam logic [CW-1:0] LS_IDLE_C = CW'(LS_IDLE);

  typedef enum logic [1:0] {
    PS_ACTIVE,
    PS_SLEEP,
    PS_WAKE
  } pwr_state_t;

  pwr_state_t    pwr_state, pwr_next;
  logic          wake;
  logic [CW-1:0] idle_cnt;
  logic          rd_pend;     // outstanding response carries SRAM read data
  logic          hold_vld;
  logic [DW-1:0] hold_rdata;
  logic          acc, in_range, hs;

  assign ram_ls = (pwr_state == PS_SLEEP);
  assign wake   = (pwr_state == PS_WAKE);

  // rst_n gates ready so nothing is accepted (and no SRAM access issued) in reset.
  assign cmd_ready = rst_n & ~ram_ls & ~wake & (~rsp_valid | rsp_ready);
  assign acc       = cmd_valid & cmd_ready;
  assign in_range  = {1'b0, cmd_addr} < DP_L;
  assign hs        = rsp_valid & rsp_ready;

  assign ram_cs   = acc & in_range;
  assign ram_we   = ram_cs & ~cmd_read;
  assign ram_wem  = ram_cs ? cmd_wmask : '0;
  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  // First response cycle bypasses ram_dout; once stalled, the captured copy is used
  // so the data stays stable even if the SRAM output changes.
  assign rsp_rdata = hold_vld ? hold_rdata : (rd_pend ? ram_dout : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rd_pend    <= 1'b0;
      hold_vld   <= 1'b0;
      hold_rdata <= '0;
    end else begin
      if (acc) begin
        rsp_valid <= 1'b1;
        rsp_err   <= ~in_range;
        rd_pend   <= in_range & cmd_read;
      end else if (hs) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rd_pend   <= 1'b0;
      end
      if (hs) begin
        hold_vld <= 1'b0;
      end else if (rsp_valid && !hold_vld) begin
        hold_vld   <= 1'b1;
        hold_rdata <= rsp_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      pwr_state <= PS_ACTIVE;
    end else begin
      pwr_state <= pwr_next;
      if (acc) begin
        idle_cnt <= '0;
      end else if (!rsp_valid && !ram_ls && idle_cnt != LS_IDLE_C) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

  // WAKE is a mandatory dead cycle after leaving light-sleep before any access.
  always_comb begin
    pwr_next = pwr_state;
    case (pwr_state)
      PS_ACTIVE: begin
        if (LS_IDLE != 0 && !acc && !rsp_valid && idle_cnt == LS_IDLE_C) begin
          pwr_next = PS_SLEEP;
        end
      end
      PS_SLEEP: begin
        if (cmd_valid) begin
          pwr_next = PS_WAKE;
        end
      end
      PS_WAKE:  pwr_next = PS_ACTIVE;
      default:  pwr_next = PS_ACTIVE;
    endcase
  end

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// tb/tb_qpu_itcm_ctrl.sv - directed self-checking bench for qpu_itcm_ctrl

module tb_qpu_itcm_ctrl;

  localparam int AW      = 17;
  localparam int DW      = 64;
  localparam int MW      = 8;
  localparam int DP      = 65536;
  localparam int LS_IDLE = 16;

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] D2 = 64'h1122_3344_AAAA_AAAA;
  localparam logic [63:0] DE = 64'hCAFE_F00D_1234_5678;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_read = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [MW-1:0] cmd_wmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          ram_sd;
  logic          ram_ds;
  logic          ram_ls;

  int n_checks = 0;
  int n_errors = 0;
  logic scramble = 1'b0;
  int found;

  always #5 clk = ~clk;

  qpu_itcm_ctrl #(
    .AW(AW), .DW(DW), .MW(MW), .DP(DP), .LS_IDLE(LS_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
  );

  // SRAM with 1-cycle read latency; scramble corrupts dout to expose missing hold logic.
  logic [DW-1:0] mem [0:DP-1];
  always @(posedge clk) begin
    if (scramble) begin
      ram_dout <= 64'hDEAD_BEEF_0BAD_F00D;
    end else if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++) begin
          if (ram_wem[b]) mem[ram_addr[15:0]][8*b +: 8] <= ram_din[8*b +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr[15:0]];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle_cmd(input logic v, input logic rd, input logic [AW-1:0] a,
                           input logic [63:0] d, input logic [7:0] m, input logic rdy);
    @(negedge clk);
    cmd_valid = v;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wmask = m;
    rsp_ready = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with a command offered during reset.
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_ram_cs", ram_cs, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    check_val("rst_ram_ls", ram_ls, 0);
    check_val("rst_sd_ds", {ram_sd, ram_ds}, 0);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;

    // Full write then back-to-back read.
    cycle_cmd(1, 0, 17'h10, D1, 8'hFF, 1);
    check_val("wr_ready", cmd_ready, 1);
    check_val("wr_cs_we", {ram_cs, ram_we}, 2'b11);
    check_val("wr_wem", ram_wem, 8'hFF);
    check_val("wr_addr", ram_addr, 17'h10);
    check_val("wr_din", ram_din, D1);
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("wr_rsp_valid", rsp_valid, 1);
    check_val("wr_rsp_rdata", rsp_rdata, 0);
    check_val("rd_cs_we", {ram_cs, ram_we}, 2'b10);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("rd_rsp_valid", rsp_valid, 1);
    check_val("rd_rsp_rdata", rsp_rdata, D1);
    check_val("rd_rsp_err", rsp_err, 0);
    check_val("idle_cs", ram_cs, 0);

    // Partial mask write.
    cycle_cmd(1, 0, 17'h10, DA, 8'h0F, 1);
    check_val("pw_cs_wem", {ram_cs, ram_wem}, 9'h10F);
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("pw_rsp_rdata", rsp_rdata, 0);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("pw_rd_rdata", rsp_rdata, D2);

    // Backpressure: 5 stalled cycles, data must come from the hold register.
    cycle_cmd(1, 1, 17'h10, 0, 0, 0);
    check_val("bp_accept_cs", ram_cs, 1);
    for (int i = 0; i < 5; i++) begin
      cycle_cmd(1, 1, 17'h10, 0, 0, 0);
      check_val("bp_rsp_valid", rsp_valid, 1);
      check_val("bp_rsp_rdata", rsp_rdata, D2);
      check_val("bp_cmd_ready", cmd_ready, 0);
      check_val("bp_ram_cs", ram_cs, 0);
      scramble = (i < 4);
    end
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("bp_hs_rdata", rsp_rdata, D2);
    check_val("bp_hs_accept", {cmd_ready, ram_cs}, 2'b11);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("bp_next_rdata", {rsp_valid, rsp_rdata}, {1'b1, D2});

    // Out-of-range address DP, then last legal address DP-1.
    cycle_cmd(1, 1, 17'h10000, 0, 0, 1);
    check_val("oor_ready", cmd_ready, 1);
    check_val("oor_cs", ram_cs, 0);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("oor_rsp", {rsp_valid, rsp_err}, 2'b11);
    check_val("oor_rdata", rsp_rdata, 0);
    cycle_cmd(1, 0, 17'h0FFFF, DE, 8'hFF, 1);
    check_val("top_wr_cs", ram_cs, 1);
    cycle_cmd(1, 1, 17'h0FFFF, 0, 0, 1);
    check_val("top_wr_err", {rsp_valid, rsp_err}, 2'b10);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("top_rd_rdata", rsp_rdata, DE);
    check_val("top_rd_err", rsp_err, 0);

    // Light-sleep entry: idle_cnt counts 0..16 then ls rises the following cycle.
    found = -1;
    for (int k = 0; k < 40 && found < 0; k++) begin
      cycle_cmd(0, 0, 0, 0, 0, 1);
      if (ram_ls) found = k;
    end
    check_val("ls_entry_cycle", found, 17);
    check_val("ls_cmd_ready", cmd_ready, 0);

    // Wake: request during ls, ls drops, wake cycle, accept on the 3rd cycle.
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("wk0_ls_ready_cs", {ram_ls, cmd_ready, ram_cs}, 3'b100);
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("wk1_ls_ready_cs", {ram_ls, cmd_ready, ram_cs}, 3'b000);
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("wk2_ls_ready_cs", {ram_ls, cmd_ready, ram_cs}, 3'b011);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("wk_rdata", {rsp_valid, rsp_rdata}, {1'b1, D2});

    // Reset while a response is stalled.
    cycle_cmd(1, 1, 17'h0FFFF, 0, 0, 0);
    cycle_cmd(1, 1, 17'h10, 0, 0, 0);
    check_val("mr_pre_valid", {rsp_valid, rsp_rdata}, {1'b1, DE});
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mr_rsp_valid", rsp_valid, 0);
    check_val("mr_rsp_rdata", rsp_rdata, 0);
    check_val("mr_ready_cs_ls", {cmd_ready, ram_cs, ram_ls}, 3'b000);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    cycle_cmd(1, 1, 17'h10, 0, 0, 1);
    check_val("mr_after_accept", {cmd_ready, ram_cs}, 2'b11);
    cycle_cmd(0, 0, 0, 0, 0, 1);
    check_val("mr_after_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, D2});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
